// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package whack_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StOver = 2'd2
    } game_state_e;

    localparam int unsigned NUM_HOLES = 8;
    localparam int unsigned HOLE_W    = 3;

    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/whack_game_controller_if.sv
// Controller <-> score evaluator handshake; master is the controller side.
interface whack_game_controller_if;
    import whack_pkg::*;

    logic [HOLE_W-1:0] user_guess;
    logic [HOLE_W-1:0] mole_pos;
    logic              eval_now;
    logic              restart_game;
    logic              mole_change;
    logic              game_over;
    logic              i_guess_correct;
    logic              i_guess_now;
    logic [7:0]        i_score;

    modport master (
        output user_guess, mole_pos, eval_now, restart_game, mole_change, game_over,
        input  i_guess_correct, i_guess_now, i_score
    );

    modport slave (
        input  user_guess, mole_pos, eval_now, restart_game, mole_change, game_over,
        output i_guess_correct, i_guess_now, i_score
    );

endinterface

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR for mole placement; reset loads SEED.
module mole_lfsr
    import whack_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [HOLE_W-1:0] o_low
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign o_low = r_lfsr[HOLE_W-1:0];

endmodule

// File: rtl/whack_game_controller.sv
// Whack-a-mole sequencer: game FSM, round timer, mole placement, button encode.
// Optional WHACK_SPEEDUP_EN shortens mole dwell as the score rises.
module whack_game_controller
    import whack_pkg::*;
#(
    parameter int unsigned TICK_CYCLES  = 100000000,
    parameter int unsigned GAME_SECONDS = 30,
    parameter int unsigned MOLE_CYCLES  = 150000000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [NUM_HOLES-1:0]    i_btn,
    whack_game_controller_if.master bus,
    output logic [5:0]              time_left,
    output logic [1:0]              state
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [27:0] MOLE_LIMIT = 28'(MOLE_CYCLES);

    game_state_e          r_state;
    logic                 r_start_prev;
    logic [NUM_HOLES-1:0] r_btn_prev;
    logic [TICK_W-1:0]    r_tick;
    logic [5:0]           r_time_left;
    logic [27:0]          r_mole_cnt;
    logic                 r_place_req;
    logic [HOLE_W-1:0]    r_user_guess;
    logic [HOLE_W-1:0]    r_mole_pos;
    logic                 r_eval_now;
    logic                 r_restart;
    logic                 r_mole_change;
    logic                 r_game_over;

    logic                 w_start_edge;
    logic [NUM_HOLES-1:0] w_btn_edge;
    logic                 w_tick_wrap;
    logic                 w_round_end;
    logic                 w_relocate;
    logic                 w_accept;
    logic [HOLE_W-1:0]    w_btn_idx;
    logic [HOLE_W-1:0]    w_lfsr_low;
    logic [HOLE_W-1:0]    w_new_pos;
    logic [27:0]          w_mole_limit;

`ifdef WHACK_SPEEDUP_EN
    logic [27:0] r_mole_limit;
    logic [1:0]  w_shift;
    logic [27:0] w_dwell;
    logic        w_unused_score_lsb;

    always_comb begin
        w_shift = (|bus.i_score[7:4]) ? 2'd3 : bus.i_score[3:2];
        w_dwell = MOLE_LIMIT >> w_shift;
        if (w_dwell == 28'd0) begin
            w_dwell = 28'd1;
        end
    end

    assign w_mole_limit       = r_mole_limit;
    assign w_unused_score_lsb = ^bus.i_score[1:0];
`else
    logic w_unused_score;

    assign w_mole_limit   = MOLE_LIMIT;
    assign w_unused_score = ^bus.i_score;
`endif

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .o_low (w_lfsr_low)
    );

    always_comb begin
        w_start_edge = i_start & ~r_start_prev;
        w_btn_edge   = i_btn & ~r_btn_prev;
        w_tick_wrap  = (r_tick == TICK_LAST);
        // Final tick of the round: a press now would strobe after game_over rises.
        w_round_end  = w_tick_wrap && (r_time_left == 6'd1);
        w_relocate   = r_place_req || bus.i_guess_correct ||
                       (r_mole_cnt == w_mole_limit - 28'd1);
        w_accept     = (r_state == StPlay) && bus.i_guess_now && (r_time_left != 6'd0) &&
                       !w_round_end && (|w_btn_edge);
        w_btn_idx    = '0;
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (w_btn_edge[i]) begin
                w_btn_idx = HOLE_W'(i);
            end
        end
        w_new_pos = (w_lfsr_low == r_mole_pos) ? r_mole_pos + HOLE_W'(1) : w_lfsr_low;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_start_prev  <= 1'b0;
            r_btn_prev    <= '0;
            r_tick        <= '0;
            r_time_left   <= 6'd0;
            r_mole_cnt    <= 28'd0;
            r_place_req   <= 1'b0;
            r_user_guess  <= '0;
            r_mole_pos    <= '0;
            r_eval_now    <= 1'b0;
            r_restart     <= 1'b0;
            r_mole_change <= 1'b0;
            r_game_over   <= 1'b0;
`ifdef WHACK_SPEEDUP_EN
            r_mole_limit  <= MOLE_LIMIT;
`endif
        end else begin
            r_start_prev  <= i_start;
            r_btn_prev    <= i_btn;
            r_restart     <= 1'b0;
            r_mole_change <= 1'b0;
            r_eval_now    <= 1'b0;
            r_place_req   <= 1'b0;
            case (r_state)
                StIdle, StOver: begin
                    if (w_start_edge) begin
                        r_state     <= StPlay;
                        r_restart   <= 1'b1;
                        r_game_over <= 1'b0;
                        r_time_left <= 6'(GAME_SECONDS);
                        r_tick      <= '0;
                        r_mole_cnt  <= 28'd0;
                        r_place_req <= 1'b1;
                    end
                end
                StPlay: begin
                    if (w_tick_wrap) begin
                        r_tick      <= '0;
                        r_time_left <= r_time_left - 6'd1;
                        if (r_time_left == 6'd1) begin
                            r_state     <= StOver;
                            r_game_over <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                    if (w_relocate) begin
                        r_mole_pos    <= w_new_pos;
                        r_mole_change <= 1'b1;
                        r_mole_cnt    <= 28'd0;
`ifdef WHACK_SPEEDUP_EN
                        r_mole_limit  <= w_dwell;
`endif
                    end else begin
                        r_mole_cnt <= r_mole_cnt + 28'd1;
                    end
                    if (w_accept) begin
                        r_user_guess <= w_btn_idx;
                        r_eval_now   <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.user_guess   = r_user_guess;
    assign bus.mole_pos     = r_mole_pos;
    assign bus.eval_now     = r_eval_now;
    assign bus.restart_game = r_restart;
    assign bus.mole_change  = r_mole_change;
    assign bus.game_over    = r_game_over;
    assign time_left        = r_time_left;
    assign state            = r_state;

endmodule
